// File: rtl/pipedmem_io_in.sv
// Switch/key input conditioner for the pipelined computer's memory-mapped I/O:
// 2-flop synchronisers, per-bit debounce, and a W1C key-press capture register.

module pipedmem_io_in_db #(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic mem_clk,
    input  logic clrn,
    input  logic i_raw,
    output logic o_stable
);
    logic             r_s1, r_s2, r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge mem_clk or negedge clrn) begin
        if (!clrn) begin
            r_s1     <= RST_VAL;
            r_s2     <= RST_VAL;
            r_stable <= RST_VAL;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            // Any return to the stable level restarts the count, so short glitches never land.
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
endmodule

module pipedmem_io_in #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        mem_clk,
    input  logic        clrn,
    input  logic [9:0]  sw_raw,
    input  logic [3:1]  key_raw,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    output logic [9:0]  sw,
    output logic [3:1]  key,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        irq
);
    localparam logic [31:0] CAP_ADDR = 32'hffff_ff14;
    // Switches idle low, keys idle high (released).
    localparam logic [12:0] RST_VEC  = {3'b111, 10'b0};

    logic [12:0] w_raw, w_stable;
    logic        w_hit;
    logic [3:1]  w_press, w_clr, w_cap_next;
    logic [3:1]  r_key_d, r_cap;
    logic        r_irq;

    assign w_raw = {key_raw, sw_raw};

    for (genvar b = 0; b < 13; b++) begin : g_db
        pipedmem_io_in_db #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RST_VAL         (RST_VEC[b])
        ) u_db (
            .mem_clk  (mem_clk),
            .clrn     (clrn),
            .i_raw    (w_raw[b]),
            .o_stable (w_stable[b])
        );
    end

    assign sw  = w_stable[9:0];
    assign key = w_stable[12:10];

    // Press is seen one edge after the debounced key falls; press beats a same-cycle clear.
    assign w_hit      = (addr == CAP_ADDR);
    assign w_press    = r_key_d & ~key;
    assign w_clr      = {3{we & w_hit}} & datain[3:1];
    assign w_cap_next = w_press | (r_cap & ~w_clr);

    always_ff @(posedge mem_clk or negedge clrn) begin
        if (!clrn) begin
            r_key_d <= 3'b111;
            r_cap   <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_key_d <= key;
            r_cap   <= w_cap_next;
            r_irq   <= |r_cap;
        end
    end

    assign irq     = r_irq;
    assign rd_hit  = w_hit;
    assign rd_data = w_hit ? {28'b0, r_cap, 1'b0} : 32'b0;
endmodule

// File: tb/tb_pipedmem_io_in.sv
// Directed + randomized bench for pipedmem_io_in against a per-edge behavioural model.

module tb_pipedmem_io_in;
    localparam int DB = 4;
    localparam logic [31:0] CAP = 32'hffff_ff14;

    logic        mem_clk = 0;
    logic        clrn = 0;
    logic [9:0]  sw_raw = '0;
    logic [3:1]  key_raw = 3'b111;
    logic [31:0] addr = '0, datain = '0;
    logic        we = 0;
    logic [9:0]  sw;
    logic [3:1]  key;
    logic        rd_hit, irq;
    logic [31:0] rd_data;

    int checks = 0, failures = 0;

    pipedmem_io_in #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
        .mem_clk(mem_clk), .clrn(clrn), .sw_raw(sw_raw), .key_raw(key_raw),
        .addr(addr), .datain(datain), .we(we), .sw(sw), .key(key),
        .rd_hit(rd_hit), .rd_data(rd_data), .irq(irq)
    );

    always #5 mem_clk = ~mem_clk;

    // Model: raw history delayed two edges; an output bit flips once its
    // delayed input has disagreed with it for DB edges in a row.
    logic [12:0] m_d1, m_d2, m_out;
    int          m_run [13];
    logic [3:1]  m_kprev, m_cap;
    logic        m_irq;

    function automatic void m_reset();
        m_d1 = {3'b111, 10'b0}; m_d2 = m_d1; m_out = m_d1;
        foreach (m_run[b]) m_run[b] = 0;
        m_kprev = 3'b111; m_cap = '0; m_irq = 0;
    endfunction

    function automatic void m_edge(logic [12:0] raw, logic w, logic [31:0] a, logic [31:0] d);
        logic [12:0] o = m_out;
        logic [3:1]  press, clr;
        for (int b = 0; b < 13; b++) begin
            if (m_d2[b] != m_out[b]) begin
                m_run[b]++;
                if (m_run[b] >= DB) begin o[b] = m_d2[b]; m_run[b] = 0; end
            end else m_run[b] = 0;
        end
        press   = m_kprev & ~m_out[12:10];
        clr     = (w && a == CAP) ? d[3:1] : 3'b000;
        m_irq   = |m_cap;
        m_cap   = press | (m_cap & ~clr);
        m_kprev = m_out[12:10];
        m_out   = o;
        m_d2    = m_d1;
        m_d1    = raw;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [12:0] raw = {key_raw, sw_raw};
        logic w = we; logic [31:0] a = addr, d = datain;
        @(posedge mem_clk);
        m_edge(raw, w, a, d);
        #1;
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".sw"},  32'(sw),  32'(m_out[9:0]));
        chk({tag, ".key"}, 32'(key), 32'(m_out[12:10]));
        chk({tag, ".irq"}, 32'(irq), 32'(m_irq));
        chk({tag, ".hit"}, 32'(rd_hit), 32'(addr == CAP));
        chk({tag, ".rd"},  rd_data, (addr == CAP) ? {28'b0, m_cap, 1'b0} : 32'b0);
    endtask

    initial begin
        m_reset();
        addr = CAP;
        #12 clrn = 1;
        step();
        chk("rst.sw", 32'(sw), 0);
        chk("rst.key", 32'(key), 32'h7);
        chk("rst.irq", 32'(irq), 0);
        chk("rst.rd", rd_data, 0);

        // Held switch change: visible after edge DB+2 only.
        sw_raw = 10'h2A5;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk("sw_lat", 32'(sw), (e < 6) ? 32'h0 : 32'h2A5);
            chk_model("sw_lat_m");
        end

        // Short key glitch is filtered.
        key_raw[2] = 0;
        repeat (3) step();
        key_raw[2] = 1;
        repeat (8) begin step(); chk("glitch.key", 32'(key), 32'h7); chk_model("glitch_m"); end
        chk("glitch.rd", rd_data, 0);

        // Real press: key, then cap, then irq on successive edges.
        key_raw[2] = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            chk("press.key", 32'(key), (e < 6) ? 32'h7 : 32'h5);
            chk("press.rd", rd_data, (e < 7) ? 32'h0 : 32'h4);
            chk("press.irq", 32'(irq), (e < 8) ? 32'h0 : 32'h1);
            chk_model("press_m");
        end
        key_raw[2] = 1;

        // W1C clear: cap drops at the write edge, irq one edge later.
        we = 1; datain = 32'hFFFF_FFF4 & 32'h4;
        step();
        we = 0;
        chk("clr.rd", rd_data, 0);
        chk("clr.irq_lag", 32'(irq), 1);
        step();
        chk("clr.irq", 32'(irq), 0);
        repeat (8) begin step(); chk_model("rel_m"); end

        // Clear write landing on the same edge as a fresh key3 press: set wins.
        key_raw[3] = 0;
        for (int e = 1; e <= 8; e++) begin
            if (e == 7) begin we = 1; datain = 32'hC; end
            step();
            we = 0;
            if (e == 7) chk("press_vs_clr.rd", rd_data, 32'h8);
            chk_model("pvc_m");
        end
        key_raw[3] = 1;
        we = 1; datain = 32'h8; step(); we = 0;
        chk("clr3.rd", rd_data, 0);
        repeat (8) step();

        // Reset mid-debounce, then recovery with input held.
        sw_raw = 10'h3FF;
        repeat (3) step();
        #2 clrn = 0; m_reset();
        #1;
        chk("async_rst.sw", 32'(sw), 0);
        chk("async_rst.rd", rd_data, 0);
        @(negedge mem_clk); clrn = 1; #1;
        for (int e = 1; e <= 6; e++) begin
            step();
            chk("post_rst.sw", 32'(sw), (e < 6) ? 32'h0 : 32'h3FF);
        end

        // Randomized: bursty inputs with mixed hold times, random reads/writes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) sw_raw = 10'($urandom);
            if ($urandom_range(0, 4) == 0) key_raw = 3'($urandom);
            case ($urandom_range(0, 3))
                0: addr = CAP;
                1: addr = 32'hffff_ff10;
                2: addr = 32'hffff_ff00;
                default: addr = $urandom;
            endcase
            we = ($urandom_range(0, 5) == 0);
            datain = $urandom;
            step();
            chk_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
